// File: rtl/div_sequencer_if.sv
// rtl/div_sequencer_if.sv - request, response, flush and shared-ALU signals of the divide sequencer
interface div_sequencer_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [4:0]      alu_ctrl;
  logic [XLEN-1:0] alu_result;
  logic            alu_c;

  modport master (
    output in_valid, in_op, in_a, in_b, flush, out_ready, alu_result, alu_c,
    input  in_ready, out_valid, out_result, alu_a, alu_b, alu_ctrl
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, flush, out_ready, alu_result, alu_c,
    output in_ready, out_valid, out_result, alu_a, alu_b, alu_ctrl
  );
endinterface

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - RV32M DIV/DIVU/REM/REMU sequencer driving the shared ALU for every step
module div_sequencer #(
  parameter int         XLEN    = 32,
  parameter logic [4:0] ALU_ADD = 5'b0_0000,
  parameter logic [4:0] ALU_SUB = 5'b1_0000
) (
  input logic          clk,
  input logic          rst_n,
  div_sequencer_if.slave bus
);
  localparam int              CW       = $clog2(XLEN);
  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ABS_A, ABS_B, ITER, FIX, DONE} state_t;

  state_t          state, state_nx;
  logic [1:0]      op;
  logic [XLEN-1:0] a_r, b_r, q, r, d, result;
  logic            sign_a, sign_b;
  logic [CW-1:0]   cnt;

  logic            div_zero, overflow;
  logic [XLEN-1:0] shifted, target;
  logic            qbit, neg;

  assign div_zero = (bus.in_b == '0);
  assign overflow = ~bus.in_op[0] && (bus.in_a == MIN_NEG) && (bus.in_b == ALL_ONES);

  // r[31] set means the 33-bit partial remainder already exceeds any divisor
  assign shifted = {r[XLEN-2:0], q[XLEN-1]};
  assign qbit    = r[XLEN-1] | bus.alu_c;
  assign target  = op[1] ? r : q;
  assign neg     = op[1] ? sign_a : (sign_a ^ sign_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (bus.flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.in_valid) state_nx = (div_zero || overflow) ? DONE : ABS_A;
        ABS_A:   state_nx = ABS_B;
        ABS_B:   state_nx = ITER;
        ITER:    if (cnt == '0) state_nx = FIX;
        FIX:     state_nx = DONE;
        DONE:    if (bus.out_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready   = (state == IDLE);
    bus.out_valid  = (state == DONE);
    bus.out_result = (state == DONE) ? result : '0;
    bus.alu_a      = '0;
    bus.alu_b      = '0;
    bus.alu_ctrl   = ALU_ADD;
    case (state)
      ABS_A: begin
        bus.alu_b    = a_r;
        bus.alu_ctrl = ALU_SUB;
      end
      ABS_B: begin
        bus.alu_b    = b_r;
        bus.alu_ctrl = ALU_SUB;
      end
      ITER: begin
        bus.alu_a    = shifted;
        bus.alu_b    = d;
        bus.alu_ctrl = ALU_SUB;
      end
      FIX: begin
        bus.alu_b    = target;
        bus.alu_ctrl = ALU_SUB;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op     <= '0;
      a_r    <= '0;
      b_r    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      q      <= '0;
      r      <= '0;
      d      <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && !bus.flush) begin
            op     <= bus.in_op;
            a_r    <= bus.in_a;
            b_r    <= bus.in_b;
            sign_a <= bus.in_a[XLEN-1] & ~bus.in_op[0];
            sign_b <= bus.in_b[XLEN-1] & ~bus.in_op[0];
            if (div_zero)      result <= bus.in_op[1] ? bus.in_a : ALL_ONES;
            else if (overflow) result <= bus.in_op[1] ? '0 : MIN_NEG;
          end
        end
        ABS_A: begin
          q <= sign_a ? bus.alu_result : a_r;
          r <= '0;
        end
        ABS_B: begin
          d   <= sign_b ? bus.alu_result : b_r;
          cnt <= CW'(XLEN - 1);
        end
        ITER: begin
          r   <= qbit ? bus.alu_result : shifted;
          q   <= {q[XLEN-2:0], qbit};
          cnt <= cnt - 1'b1;
        end
        FIX: result <= neg ? bus.alu_result : target;
        default: ;
      endcase
    end
  end
endmodule
